// File: rtl/regfile_multiport.sv
// Multiport integer register file for the CPU datapath.
// Combinational read ports, one synchronous write port, optional same-cycle
// write-to-read forwarding, and an optional free-running cycle counter held
// in one of the architectural registers.
module regfile_multiport #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int SP_IDX   = 2,
  parameter int SP_INIT  = 255,
  parameter int CYC_IDX  = 30,
  parameter int BYPASS   = 1
) (
  input  logic                       CLOCK_50,
  input  logic                       RESET_N,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  input  logic                       reg_write,
  input  logic [ADDR_W-1:0]          dst,
  input  logic [DATA_W-1:0]          wb,
  input  logic                       cyc_freeze
);

  // Reset image of the stack pointer, truncated to the register width.
  localparam logic [DATA_W-1:0] SP_RST = DATA_W'(SP_INIT);
  localparam logic [ADDR_W-1:0] SP_A   = ADDR_W'(SP_IDX);
  localparam logic [ADDR_W-1:0] CYC_A  = ADDR_W'(CYC_IDX);
  localparam bit                CYC_EN = (CYC_IDX != 0);
  localparam bit                BYP_EN = (BYPASS != 0);

  // Reject inconsistent configurations at elaboration time.
  if (ADDR_W != $clog2(NUM_REGS)) begin : g_chk_addr
    $error("regfile_multiport: ADDR_W must equal log2(NUM_REGS)");
  end
  if ((NUM_REGS < 4) || ((NUM_REGS & (NUM_REGS - 1)) != 0)) begin : g_chk_regs
    $error("regfile_multiport: NUM_REGS must be a power of two and at least 4");
  end
  if ((NUM_RD < 1) || (NUM_RD > 4)) begin : g_chk_rd
    $error("regfile_multiport: NUM_RD must be in 1..4");
  end
  if ((SP_IDX <= 0) || (SP_IDX >= NUM_REGS)) begin : g_chk_sp
    $error("regfile_multiport: SP_IDX must be in 1..NUM_REGS-1");
  end
  if ((CYC_IDX < 0) || (CYC_IDX >= NUM_REGS)) begin : g_chk_cyc
    $error("regfile_multiport: CYC_IDX must be in 0..NUM_REGS-1");
  end

  // Modulo-2^DATA_W increment used by the cycle counter.
  function automatic logic [DATA_W-1:0] inc_wrap(input logic [DATA_W-1:0] v);
    return v + DATA_W'(1);
  endfunction

  // Register 0 is held at zero by never enabling a write to it, so the read
  // mux needs no special case for address 0.
  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic              wr_en;

  assign wr_en = reg_write && (dst != '0);

  // Next-state: counter increment first, so an explicit write overrides it.
  always_comb begin
    regs_d = regs_q;
    if (CYC_EN && !cyc_freeze) begin
      regs_d[CYC_A] = inc_wrap(regs_q[CYC_A]);
    end
    if (wr_en) begin
      regs_d[dst] = wb;
    end
  end

  // Register array with asynchronous clear to the reset image.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[ADDR_W'(i)] <= '0;
      end
      regs_q[SP_A] <= SP_RST;
    end else begin
      regs_q <= regs_d;
    end
  end

  // Read ports: array lookup, with the pending write forwarded on a match.
  // Forwarding is suppressed while reset is held so reads show reset contents.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      if (BYP_EN && RESET_N && wr_en && (rd_addr[i*ADDR_W +: ADDR_W] == dst)) begin
        rd_data[i*DATA_W +: DATA_W] = wb;
      end else begin
        rd_data[i*DATA_W +: DATA_W] = regs_q[rd_addr[i*ADDR_W +: ADDR_W]];
      end
    end
  end

endmodule

// File: tb/tb_regfile_multiport.sv
// Directed bench for regfile_multiport: three instances cover the default
// 4-port forwarding build, a non-forwarding build, and a 16-bit/16-entry
// build without a cycle counter.
module tb_regfile_multiport;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Shared write/control inputs for instances a and b
  logic        we;
  logic [4:0]  wdst;
  logic [31:0] wdat;
  logic        freeze;

  // Instance a: 4 read ports, forwarding on
  logic [19:0]  a_ra;
  logic [127:0] a_rd;
  // Instance b: 2 read ports, forwarding off
  logic [9:0]   b_ra;
  logic [63:0]  b_rd;
  // Instance c: 16-bit, 16 registers, no counter
  logic         c_we;
  logic [3:0]   c_dst;
  logic [15:0]  c_wb;
  logic [7:0]   c_ra;
  logic [31:0]  c_rd;

  regfile_multiport #(.NUM_RD(4), .BYPASS(1)) u_a (
    .CLOCK_50(clk), .RESET_N(rst_n), .rd_addr(a_ra), .rd_data(a_rd),
    .reg_write(we), .dst(wdst), .wb(wdat), .cyc_freeze(freeze));

  regfile_multiport #(.NUM_RD(2), .BYPASS(0)) u_b (
    .CLOCK_50(clk), .RESET_N(rst_n), .rd_addr(b_ra), .rd_data(b_rd),
    .reg_write(we), .dst(wdst), .wb(wdat), .cyc_freeze(freeze));

  regfile_multiport #(.DATA_W(16), .NUM_REGS(16), .ADDR_W(4), .NUM_RD(2),
                      .SP_INIT(32'h1FFFF), .CYC_IDX(0), .BYPASS(1)) u_c (
    .CLOCK_50(clk), .RESET_N(rst_n), .rd_addr(c_ra), .rd_data(c_rd),
    .reg_write(c_we), .dst(c_dst), .wb(c_wb), .cyc_freeze(1'b0));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(input logic [4:0] p0, input logic [4:0] p1,
                       input logic [4:0] p2, input logic [4:0] p3);
    a_ra = {p3, p2, p1, p0};
  endtask

  function automatic logic [31:0] a_port(input int i);
    return a_rd[i*32 +: 32];
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n  = 1'b0;
    we     = 1'b0;
    wdst   = '0;
    wdat   = '0;
    freeze = 1'b0;
    c_we   = 1'b0;
    c_dst  = '0;
    c_wb   = '0;
    set_a(5'd30, 5'd2, 5'd5, 5'd0);
    b_ra   = {5'd0, 5'd2};
    c_ra   = {4'd15, 4'd2};
    #12;

    // Reset contents
    chk("rst_a_r30", a_port(0), 32'h0);
    chk("rst_a_sp",  a_port(1), 32'h0000_00FF);
    chk("rst_a_r5",  a_port(2), 32'h0);
    chk("rst_a_r0",  a_port(3), 32'h0);
    chk("rst_b_sp",  b_rd[31:0], 32'h0000_00FF);
    chk("rst_c_sp",  {16'h0, c_rd[15:0]}, 32'h0000_FFFF);
    chk("rst_c_r15", {16'h0, c_rd[31:16]}, 32'h0);

    // Counter: 10 edges after release
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("cyc_10", a_port(0), 32'd10);
    freeze = 1'b1;
    repeat (3) tick();
    chk("cyc_frozen", a_port(0), 32'd10);
    freeze = 1'b0;
    we = 1'b1; wdst = 5'd30; wdat = 32'hFFFF_FFFF;
    #1;
    chk("cyc_wr_fwd", a_port(0), 32'hFFFF_FFFF);
    tick();
    we = 1'b0;
    #1;
    chk("cyc_wr_wins", a_port(0), 32'hFFFF_FFFF);
    tick();
    chk("cyc_wrap", a_port(0), 32'h0);

    // Multiport: regs[1..4] = 1..4
    for (int r = 1; r <= 4; r++) begin
      we = 1'b1; wdst = 5'(r); wdat = 32'(r);
      tick();
    end
    we = 1'b0;
    set_a(5'd1, 5'd2, 5'd3, 5'd4);
    #1;
    for (int p = 0; p < 4; p++) chk($sformatf("mp_distinct%0d", p), a_port(p), 32'(p + 1));
    set_a(5'd3, 5'd3, 5'd3, 5'd3);
    #1;
    for (int p = 0; p < 4; p++) chk($sformatf("mp_same%0d", p), a_port(p), 32'd3);

    // Forwarding versus no forwarding
    set_a(5'd7, 5'd5, 5'd0, 5'd0);
    b_ra = {5'd0, 5'd7};
    we = 1'b1; wdst = 5'd7; wdat = 32'h1234_5678;
    #1;
    chk("byp_a_hit",  a_port(0), 32'h1234_5678);
    chk("byp_a_miss", a_port(1), 32'h0);
    chk("nobyp_b_old", b_rd[31:0], 32'h0);
    tick();
    we = 1'b0;
    #1;
    chk("wr_a_r7", a_port(0), 32'h1234_5678);
    chk("wr_b_r7", b_rd[31:0], 32'h1234_5678);

    // Register 0 is never written nor forwarded
    set_a(5'd0, 5'd0, 5'd0, 5'd0);
    we = 1'b1; wdst = 5'd0; wdat = 32'hFFFF_FFFF;
    #1;
    for (int p = 0; p < 4; p++) chk($sformatf("r0_pre%0d", p), a_port(p), 32'h0);
    tick();
    we = 1'b0;
    #1;
    for (int p = 0; p < 4; p++) chk($sformatf("r0_post%0d", p), a_port(p), 32'h0);

    // Asynchronous reset mid-cycle
    we = 1'b1; wdst = 5'd5; wdat = 32'hDEAD_BEEF;
    tick();
    we = 1'b0;
    set_a(5'd5, 5'd2, 5'd30, 5'd0);
    #1;
    chk("pre_rst_r5", a_port(0), 32'hDEAD_BEEF);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_r5",  a_port(0), 32'h0);
    chk("arst_sp",  a_port(1), 32'h0000_00FF);
    chk("arst_r30", a_port(2), 32'h0);
    we = 1'b1; wdst = 5'd5; wdat = 32'h1111_1111;
    #1;
    chk("arst_nofwd", a_port(0), 32'h0);
    tick();
    chk("arst_nowr", a_port(0), 32'h0);
    chk("arst_nocnt", a_port(2), 32'h0);
    we = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) tick();
    chk("cyc_after_rst", a_port(2), 32'd3);

    // 16-bit build: truncated SP, register 15 never counts
    chk("c_sp_trunc", {16'h0, c_rd[15:0]}, 32'h0000_FFFF);
    chk("c_r15_idle", {16'h0, c_rd[31:16]}, 32'h0);
    c_we = 1'b1; c_dst = 4'd15; c_wb = 16'hABCD;
    #1;
    chk("c_r15_fwd", {16'h0, c_rd[31:16]}, 32'h0000_ABCD);
    tick();
    c_we = 1'b0;
    tick();
    chk("c_r15_hold", {16'h0, c_rd[31:16]}, 32'h0000_ABCD);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
